// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants and state type for the Morse message sequencer
package morse_pkg;

    localparam int PATTERN_W      = 13;
    localparam int LETTER_W       = 3;
    localparam int WORD_GAP_UNITS = 7;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT    = 3'd2,
        S_GAP      = 3'd3,
        S_DONE     = 3'd4
`ifdef MORSE_REPEAT_EN
        ,
        S_WORD_GAP = 3'd5
`endif
    } morse_state_e;

endpackage

// File: rtl/morse_tick_gen.sv
// rtl/morse_tick_gen.sv - unit-rate prescaler with synchronous reload and expiry strobe
module morse_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic reload_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is suppressed while reloading so the first strobe lands a full period out.
    always_comb begin
        tick_o = 1'b0;
        cnt_d  = cnt_q - CNT_W'(1);
        if (reload_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            tick_o = 1'b1;
            cnt_d  = RELOAD;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// rtl/morse_sequencer.sv - plays a captured message of letter codes; MORSE_REPEAT_EN adds looping with a word gap
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int MAX_LEN   = 8,
    parameter int TICK_DIV  = 25000000,
    parameter int GAP_UNITS = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [LETTER_W*MAX_LEN-1:0]    msg,
    input  logic [$clog2(MAX_LEN+1)-1:0]   msg_len,
    input  logic                           repeat_mode,
    output logic [LETTER_W-1:0]            letter_sel,
    output logic                           load_n,
    output logic                           shift_en,
    output logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0] letter_idx,
    output logic                           busy,
    output logic                           done
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int UNIT_W = $clog2(PATTERN_W + GAP_UNITS + WORD_GAP_UNITS + 1);

    morse_state_e           state_q, state_d;
    logic [LETTER_W-1:0]    code_q [MAX_LEN];
    logic [LETTER_W-1:0]    code_d [MAX_LEN];
    logic [LEN_W-1:0]       len_q, len_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LETTER_W-1:0]    sel_q, sel_d;
    logic [UNIT_W-1:0]      unit_q, unit_d;
    logic                   reload;
    logic                   tick;
    logic [LEN_W-1:0]       len_clamped;
    logic                   last_letter;
    morse_state_e           adv_state;
    logic [IDX_W-1:0]       adv_idx;

`ifndef MORSE_REPEAT_EN
    logic unused_repeat;
    assign unused_repeat = repeat_mode;
`endif

    morse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .reload_i (reload),
        .tick_o   (tick)
    );

    assign len_clamped = (msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : msg_len;
    assign last_letter = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

    // Where a letter goes once its trailing gap has elapsed.
    always_comb begin
        adv_idx   = idx_q + IDX_W'(1);
        adv_state = S_LOAD;
        if (last_letter) begin
            adv_idx   = idx_q;
            adv_state = S_DONE;
`ifdef MORSE_REPEAT_EN
            if (repeat_mode) begin
                adv_state = S_WORD_GAP;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        unit_d  = unit_q;
        reload  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        code_d[i] = msg[LETTER_W*i +: LETTER_W];
                    end
                    len_d   = len_clamped;
                    idx_d   = '0;
                    state_d = (len_clamped == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                sel_d   = code_q[idx_q];
                unit_d  = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                reload = 1'b0;
                if (tick) begin
                    if (unit_q == UNIT_W'(PATTERN_W - 1)) begin
                        unit_d = '0;
                        if (GAP_UNITS == 0) begin
                            state_d = adv_state;
                            idx_d   = adv_idx;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        unit_d = unit_q + UNIT_W'(1);
                    end
                end
            end
            S_GAP: begin
                reload = 1'b0;
                if (tick) begin
                    if (unit_q == UNIT_W'(GAP_UNITS - 1)) begin
                        unit_d  = '0;
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end else begin
                        unit_d = unit_q + UNIT_W'(1);
                    end
                end
            end
`ifdef MORSE_REPEAT_EN
            S_WORD_GAP: begin
                reload = 1'b0;
                if (tick) begin
                    if (unit_q == UNIT_W'(WORD_GAP_UNITS - 1)) begin
                        unit_d  = '0;
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        unit_d = unit_q + UNIT_W'(1);
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                code_q[i] <= '0;
            end
            len_q  <= '0;
            idx_q  <= '0;
            sel_q  <= '0;
            unit_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            unit_q  <= unit_d;
        end
    end

    // The new code is presented during the load cycle itself so the shifter captures it.
    assign letter_sel = (state_q == S_LOAD) ? code_q[idx_q] : sel_q;
    assign load_n     = (state_q != S_LOAD);
    assign shift_en   = (state_q == S_SHIFT) && tick;
    assign letter_idx = idx_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_morse_sequencer.sv
// tb/tb_morse_sequencer.sv - directed bench with a timeline model checked every cycle
module tb_morse_sequencer;

    localparam int MAX_LEN = 8;
    localparam int TD      = 4;
    localparam int GAP     = 2;
    localparam int PAT     = 13;
    localparam int PER     = (PAT + GAP) * TD + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        repeat_mode = 1'b0;
    logic [23:0] msg = '0;
    logic [3:0]  msg_len = '0;
    logic [2:0]  letter_sel;
    logic        load_n;
    logic        shift_en;
    logic [2:0]  letter_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    morse_sequencer #(
        .MAX_LEN   (MAX_LEN),
        .TICK_DIV  (TD),
        .GAP_UNITS (GAP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .msg         (msg),
        .msg_len     (msg_len),
        .repeat_mode (repeat_mode),
        .letter_sel  (letter_sel),
        .load_n      (load_n),
        .shift_en    (shift_en),
        .letter_idx  (letter_idx),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Model: a message accepted at cycle a loads letter j at a+1+j*PER and finishes at a+1+n*PER.
    bit         m_act = 0;
    int         m_a, m_n, m_sel, m_idx;
    logic [2:0] m_code [MAX_LEN];
    int         e_sel, e_ld, e_sh, e_idx, e_busy, e_done, r, j, o;
    int         ld_cyc[$], ld_sel[$], ld_idx[$], sh_cyc[$];
    int         done_cyc, acc_cyc;

    initial begin
        m_sel = 0;
        m_idx = 0;
    end

    always @(negedge clock) begin
        e_sel = m_sel; e_idx = m_idx; e_ld = 1; e_sh = 0; e_busy = 0; e_done = 0;
        if (!reset) begin
            m_act = 0; m_sel = 0; m_idx = 0;
            e_sel = 0; e_idx = 0;
        end else if (m_act && cyc > m_a) begin
            r = cyc - m_a - 1;
            if (r < m_n * PER) begin
                j = r / PER;
                o = r % PER;
                e_sel  = m_code[j];
                e_idx  = j;
                e_ld   = (o != 0) ? 1 : 0;
                e_sh   = (o != 0 && o % TD == 0 && o / TD <= PAT) ? 1 : 0;
                e_busy = 1;
            end else begin
                e_done = 1;
                e_idx  = (m_n > 0) ? m_n - 1 : 0;
                if (m_n > 0) e_sel = m_code[m_n-1];
                m_sel = e_sel;
                m_idx = e_idx;
                m_act = 0;
            end
        end
        chk("letter_sel", int'(letter_sel), e_sel);
        chk("load_n", int'(load_n), e_ld);
        chk("shift_en", int'(shift_en), e_sh);
        chk("letter_idx", int'(letter_idx), e_idx);
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        if (!load_n) begin
            ld_cyc.push_back(cyc);
            ld_sel.push_back(int'(letter_sel));
            ld_idx.push_back(int'(letter_idx));
        end
        if (shift_en) sh_cyc.push_back(cyc);
        if (done) done_cyc = cyc;
        if (reset && !m_act && e_done == 0 && start) begin
            m_act   = 1;
            m_a     = cyc;
            acc_cyc = cyc;
            m_n     = (msg_len > 4'(MAX_LEN)) ? MAX_LEN : int'(msg_len);
            for (int i = 0; i < MAX_LEN; i++) m_code[i] = msg[3*i +: 3];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_ev();
        ld_cyc.delete(); ld_sel.delete(); ld_idx.delete(); sh_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic start_msg(input logic [23:0] m, input logic [3:0] l);
        step();
        msg = m; msg_len = l; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        chk(name, int'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, k;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Single letter, code 5
        clr_ev();
        start_msg(24'o00000005, 4'd1);
        wait_done(PER + 10, "done_len1");
        step();
        chk("len1_loads", ld_cyc.size(), 1);
        chk("len1_strobes", sh_cyc.size(), 13);
        if (ld_cyc.size() == 1 && sh_cyc.size() == 13) begin
            chk("len1_sel", ld_sel[0], 5);
            chk("len1_first_strobe", sh_cyc[0] - ld_cyc[0], 4);
            chk("len1_last_strobe", sh_cyc[12] - ld_cyc[0], 52);
            chk("len1_done_after", done_cyc - sh_cyc[12], 9);
        end

        // Three letters 2,0,7
        clr_ev();
        start_msg(24'o00000702, 4'd3);
        wait_done(3 * PER + 10, "done_len3");
        step();
        chk("len3_loads", ld_cyc.size(), 3);
        chk("len3_strobes", sh_cyc.size(), 39);
        if (ld_cyc.size() == 3) begin
            chk("len3_sel0", ld_sel[0], 2);
            chk("len3_sel1", ld_sel[1], 0);
            chk("len3_sel2", ld_sel[2], 7);
            chk("len3_idx2", ld_idx[2], 2);
            chk("len3_space01", ld_cyc[1] - ld_cyc[0], 61);
            chk("len3_space12", ld_cyc[2] - ld_cyc[1], 61);
        end

        // Empty message
        clr_ev();
        start_msg(24'o77777777, 4'd0);
        wait_done(5, "done_len0");
        step();
        chk("len0_loads", ld_cyc.size(), 0);
        chk("len0_strobes", sh_cyc.size(), 0);
        chk("len0_latency", done_cyc - acc_cyc, 1);

        // Over-long length clamps to MAX_LEN
        clr_ev();
`ifndef MORSE_REPEAT_EN
        repeat_mode = 1'b1;
`endif
        start_msg(24'o76543210, 4'd12);
        wait_done(MAX_LEN * PER + 10, "done_clamp");
        step();
        repeat_mode = 1'b0;
        chk("clamp_loads", ld_cyc.size(), 8);
        if (ld_cyc.size() == 8) begin
            chk("clamp_sel7", ld_sel[7], 7);
            chk("clamp_idx7", ld_idx[7], 7);
        end

        // Reset in the middle of a letter
        clr_ev();
        start_msg(24'o00000033, 4'd2);
        k = 0;
        for (int i = 0; i < 200 && k < 5; i++) begin
            @(negedge clock);
            if (shift_en) k++;
        end
        chk("reached_strobe5", k, 5);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_load_n", int'(load_n), 1);
        chk("rst_shift_en", int'(shift_en), 0);
        chk("rst_sel", int'(letter_sel), 0);
        chk("rst_idx", int'(letter_idx), 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        clr_ev();
        repeat (100) step();
        chk("post_rst_strobes", sh_cyc.size(), 0);
        chk("post_rst_loads", ld_cyc.size(), 0);
        start_msg(24'o00000036, 4'd1);
        wait_done(PER + 10, "done_after_rst");
        step();
        chk("after_rst_loads", ld_cyc.size(), 1);
        if (ld_cyc.size() == 1) begin
            chk("after_rst_sel", ld_sel[0], 6);
            chk("after_rst_idx", ld_idx[0], 0);
        end

        // start held high, msg changed while busy, immediate restart
        clr_ev();
        step();
        msg = 24'o00000043; msg_len = 4'd2; start = 1'b1;
        repeat (30) step();
        msg = 24'o00000011;
        wait_done(2 * PER + 10, "done_held1");
        d1 = cyc;
        step();
        step();
        start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        wait_done(2 * PER + 10, "done_held2");
        step();
        chk("held_loads", ld_cyc.size(), 4);
        if (ld_cyc.size() == 4) begin
            chk("held_sel0", ld_sel[0], 3);
            chk("held_sel1", ld_sel[1], 4);
            chk("held_restart_at", ld_cyc[2] - d1, 2);
            chk("held_sel2", ld_sel[2], 1);
            chk("held_sel3", ld_sel[3], 1);
        end

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
